// File: rtl/branch_ctrl.sv
// Control-flow sequencer for the 5-stage RV32I pipeline: taken-branch redirect
// handshake, IF/ID and ID/EX flush/stall generation, load-use interlock, perf counters.
module branch_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_ctrl,
    input  logic             ex_br_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             redirect_ready,
    input  logic             cnt_clr,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             redirect_misaligned,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] cnt_ctrl,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic {RUN, REDIRECT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t state, state_nxt;
    logic   ctrl_ev, taken_ev, hazard, stall_ev;

    always_comb begin
        ctrl_ev  = (state == RUN) && ex_valid && ex_is_ctrl;
        taken_ev = ctrl_ev && ex_br_taken;
        hazard   = (state == RUN) && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        // A taken redirect squashes the dependent instruction, so it overrides the interlock.
        stall_ev = hazard && !taken_ev;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt   = state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state)
            RUN: begin
                if (taken_ev) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_nxt   = REDIRECT;
                end else if (stall_ev) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            REDIRECT: begin
                stall_if    = 1'b1;
                flush_if_id = 1'b1;
                if (redirect_ready) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // The state flop doubles as the registered request, so reset drops it at once.
    assign redirect_valid = (state == REDIRECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc         <= '0;
            redirect_misaligned <= 1'b0;
        end else if (taken_ev) begin
            redirect_pc         <= ex_target;
            redirect_misaligned <= ex_target[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ctrl  <= '0;
            cnt_taken <= '0;
            cnt_stall <= '0;
        end else if (cnt_clr) begin
            cnt_ctrl  <= '0;
            cnt_taken <= '0;
            cnt_stall <= '0;
        end else begin
            if (ctrl_ev)  cnt_ctrl  <= cnt_ctrl + CNT_ONE;
            if (taken_ev) cnt_taken <= cnt_taken + CNT_ONE;
            if (stall_ev) cnt_stall <= cnt_stall + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic compared
// against an event-level model of redirects, interlocks and counters.
module tb_branch_ctrl;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid, ex_is_ctrl, ex_br_taken, ex_is_load;
    logic [XLEN-1:0]  ex_target;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             id_use_rs1, id_use_rs2, redirect_ready, cnt_clr;
    logic             redirect_valid, redirect_misaligned;
    logic [XLEN-1:0]  redirect_pc;
    logic             stall_if, stall_id, flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] cnt_ctrl, cnt_taken, cnt_stall;

    branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_br_taken(ex_br_taken),
        .ex_target(ex_target), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .redirect_ready(redirect_ready), .cnt_clr(cnt_clr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_misaligned(redirect_misaligned),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .cnt_ctrl(cnt_ctrl), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: is a redirect owed to fetch, which PC, and plain event tallies.
    bit              m_redir;
    logic [XLEN-1:0] m_pc;
    int              m_ctrl, m_taken, m_stall;

    function automatic bit m_is_taken();
        return !m_redir && ex_valid && ex_is_ctrl && ex_br_taken;
    endfunction

    function automatic bit m_is_hazard();
        if (m_redir || !ex_valid || !ex_is_load || ex_rd == 5'd0) return 1'b0;
        return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    endfunction

    // Expected {stall_if, stall_id, flush_if_id, flush_id_ex}.
    function automatic logic [3:0] m_ctl();
        if (m_redir)       return 4'b1010;
        if (m_is_taken())  return 4'b0011;
        if (m_is_hazard()) return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] dut_ctl();
        return {stall_if, stall_id, flush_if_id, flush_id_ex};
    endfunction

    task automatic idle();
        ex_valid = 0; ex_is_ctrl = 0; ex_br_taken = 0; ex_is_load = 0;
        ex_target = '0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; redirect_ready = 0; cnt_clr = 0;
    endtask

    task automatic tick();
        bit tk, hz;
        tk = m_is_taken();
        hz = m_is_hazard();
        if (m_redir) begin
            if (redirect_ready) m_redir = 0;
        end else begin
            if (ex_valid && ex_is_ctrl) m_ctrl = (m_ctrl + 1) % CNT_MOD;
            if (tk) begin
                m_taken = (m_taken + 1) % CNT_MOD;
                m_redir = 1;
                m_pc    = ex_target;
            end else if (hz) begin
                m_stall = (m_stall + 1) % CNT_MOD;
            end
        end
        if (cnt_clr) begin m_ctrl = 0; m_taken = 0; m_stall = 0; end
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_redir = 0; m_pc = '0; m_ctrl = 0; m_taken = 0; m_stall = 0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic set_taken(input logic [XLEN-1:0] tgt);
        idle();
        ex_valid = 1; ex_is_ctrl = 1; ex_br_taken = 1; ex_target = tgt;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        total++; if (dut_ctl() !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", dut_ctl()); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
        total++; if (redirect_pc !== '0 || redirect_misaligned !== 1'b0) begin bad++; $display("FAIL reset_pc got=%h/%b exp=0/0", redirect_pc, redirect_misaligned); end
        total++; if ({cnt_ctrl, cnt_taken, cnt_stall} !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_ctrl, cnt_taken, cnt_stall); end
    endtask

    task automatic test_beq();
        set_taken(32'h0000_0100);
        redirect_ready = 1;
        #2;
        total++; if (dut_ctl() !== 4'b0011) begin bad++; $display("FAIL beq_flush_T got=%b exp=0011", dut_ctl()); end
        tick();
        idle(); redirect_ready = 1; #2;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin bad++; $display("FAIL beq_rv_T1 got=%b/%h exp=1/00000100", redirect_valid, redirect_pc); end
        total++; if (dut_ctl() !== 4'b1010) begin bad++; $display("FAIL beq_ctl_T1 got=%b exp=1010", dut_ctl()); end
        tick();
        idle(); #2;
        total++; if (redirect_valid !== 1'b0 || dut_ctl() !== 4'b0000) begin bad++; $display("FAIL beq_T2 got rv=%b ctl=%b exp rv=0 ctl=0000", redirect_valid, dut_ctl()); end
        total++; if (cnt_ctrl !== 4'd1 || cnt_taken !== 4'd1) begin bad++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", cnt_ctrl, cnt_taken); end
    endtask

    task automatic test_redirect_wait();
        int held;
        held = 0;
        set_taken(32'h0000_2000);
        tick();
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'($urandom); ex_is_ctrl = 1; ex_br_taken = 1'($urandom);
            ex_is_load = 1'($urandom); ex_target = $urandom; ex_rd = 5'($urandom_range(1, 3));
            id_rs1 = ex_rd; id_use_rs1 = 1;
            redirect_ready = (i == 3);
            #2;
            if (redirect_valid === 1'b1) held++;
            total++; if (redirect_pc !== 32'h2000) begin bad++; $display("FAIL wait_pc[%0d] got=%h exp=00002000", i, redirect_pc); end
            total++; if (dut_ctl() !== 4'b1010) begin bad++; $display("FAIL wait_ctl[%0d] got=%b exp=1010", i, dut_ctl()); end
            tick();
        end
        idle(); #2;
        total++; if (held != 4 || redirect_valid !== 1'b0) begin bad++; $display("FAIL wait_held got=%0d cycles rv_after=%b exp=4 cycles rv_after=0", held, redirect_valid); end
        total++; if (cnt_ctrl !== 4'd2 || cnt_taken !== 4'd2 || cnt_stall !== 4'd0) begin bad++; $display("FAIL wait_cnt got=%0d/%0d/%0d exp=2/2/0", cnt_ctrl, cnt_taken, cnt_stall); end
    endtask

    task automatic test_load_use();
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 7; id_use_rs1 = 1; id_rs2 = 5; id_use_rs2 = 1;
        #2;
        total++; if (dut_ctl() !== 4'b1101) begin bad++; $display("FAIL lu_stall got=%b exp=1101", dut_ctl()); end
        tick();
        idle(); #2;
        total++; if (dut_ctl() !== 4'b0000 || cnt_stall !== 4'd1) begin bad++; $display("FAIL lu_after got ctl=%b stall_cnt=%0d exp ctl=0000 stall_cnt=1", dut_ctl(), cnt_stall); end
        ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1; id_rs1 = 0; id_use_rs1 = 1;
        #2;
        total++; if (dut_ctl() !== 4'b0000) begin bad++; $display("FAIL lu_x0 got=%b exp=0000", dut_ctl()); end
        tick();
        idle(); #2;
        total++; if (cnt_stall !== 4'd1) begin bad++; $display("FAIL lu_x0_cnt got=%0d exp=1", cnt_stall); end
    endtask

    task automatic test_taken_vs_load();
        set_taken(32'h0000_0400);
        ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; redirect_ready = 1;
        #2;
        total++; if (dut_ctl() !== 4'b0011) begin bad++; $display("FAIL tvl_ctl got=%b exp=0011", dut_ctl()); end
        tick();
        idle(); redirect_ready = 1; #2;
        total++; if (cnt_stall !== 4'd1 || redirect_pc !== 32'h400) begin bad++; $display("FAIL tvl_cnt got stall_cnt=%0d pc=%h exp 1/00000400", cnt_stall, redirect_pc); end
        tick();
    endtask

    task automatic test_misaligned();
        set_taken(32'h0000_0102);
        tick();
        idle(); redirect_ready = 1; #2;
        total++; if (redirect_valid !== 1'b1 || redirect_misaligned !== 1'b1 || redirect_pc !== 32'h102) begin bad++; $display("FAIL misal got rv=%b mis=%b pc=%h exp 1/1/00000102", redirect_valid, redirect_misaligned, redirect_pc); end
        tick();
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            set_taken(32'h1000 + 32'(i * 4));
            tick();
            idle(); redirect_ready = 1;
            tick();
            if (i == 14) begin
                total++; if (cnt_taken !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", cnt_taken); end
            end
        end
        idle(); #2;
        total++; if (cnt_taken !== 4'd0 || cnt_ctrl !== 4'd0) begin bad++; $display("FAIL wrap_16 got=%0d/%0d exp=0/0", cnt_taken, cnt_ctrl); end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) begin
            set_taken(32'h3000); tick();
            idle(); redirect_ready = 1; tick();
        end
        idle(); #2;
        total++; if (cnt_taken !== 4'd3) begin bad++; $display("FAIL clr_pre got=%0d exp=3", cnt_taken); end
        set_taken(32'h3008); cnt_clr = 1;
        tick();
        idle(); redirect_ready = 1; #2;
        total++; if (cnt_taken !== 4'd0 || cnt_ctrl !== 4'd0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h3008) begin bad++; $display("FAIL clr_taken got cnt=%0d/%0d rv=%b pc=%h exp 0/0/1/00003008", cnt_taken, cnt_ctrl, redirect_valid, redirect_pc); end
        tick();
    endtask

    task automatic test_reset_mid_redirect();
        set_taken(32'h0000_5000);
        tick();
        idle(); #1;
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", redirect_valid); end
        rst_n = 0;
        model_reset();
        #1;
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin bad++; $display("FAIL rstmid_async got rv=%b pc=%h exp 0/00000000", redirect_valid, redirect_pc); end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        ex_valid = 1; ex_is_load = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
        #2;
        total++; if (dut_ctl() !== 4'b1101 || redirect_valid !== 1'b0) begin bad++; $display("FAIL rstmid_run got ctl=%b rv=%b exp 1101/0", dut_ctl(), redirect_valid); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_is_ctrl = ($urandom_range(0, 2) == 0);
            ex_br_taken = 1'($urandom);
            ex_is_load = 1'($urandom);
            ex_target = $urandom;
            ex_rd = 5'($urandom_range(0, 3));
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            redirect_ready = 1'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
            #2;
            total++; if (dut_ctl() !== m_ctl()) begin bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i, dut_ctl(), m_ctl()); end
            total++; if (redirect_valid !== m_redir || (m_redir && (redirect_pc !== m_pc || redirect_misaligned !== m_pc[1]))) begin
                bad++; $display("FAIL rnd_redir[%0d] got rv=%b pc=%h mis=%b exp rv=%b pc=%h mis=%b", i, redirect_valid, redirect_pc, redirect_misaligned, m_redir, m_pc, m_pc[1]);
            end
            total++; if (int'(cnt_ctrl) != m_ctrl || int'(cnt_taken) != m_taken || int'(cnt_stall) != m_stall) begin
                bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, cnt_ctrl, cnt_taken, cnt_stall, m_ctrl, m_taken, m_stall);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_beq();
        test_redirect_wait();
        test_load_use();
        test_taken_vs_load();
        test_misaligned();
        test_counter_wrap();
        test_clr();
        test_reset_mid_redirect();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
